// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter (8N1, optional parity).
//
// Bytes stored to DATA are queued in a small FIFO and shifted out LSB first
// on tx at a bit period of DIV+1 clocks. irq is a level request raised when
// the transmitter is idle with an empty FIFO and IRQEN[0] is set.
//
// Register map (address[3:0]):
//   0x0 DATA   W: push data_in[7:0]; reads 0
//   0x1 DIV    R/W: [15:0] divisor, [16] odd parity (parity build only)
//   0x2 STATUS R: {count[3:0], overflow, empty, full, busy}; W: bit 3 clears overflow
//   0x3 IRQEN  R/W: [0] interrupt enable
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   ce, rw    chip enable and direction from the decoder (rw=1 store)
//   address   register select
//   data_in   store data
//   data_out  read data, combinational, 0 when not read-selected
//   tx        serial output, idle high
//   irq       level interrupt request
//
// Build option: define UART_TX_PARITY_EN to add a parity bit between the
// data bits and the stop bit (even by default, odd when DIV[16] is set).
//
// FSM states:
//   state  | meaning
//   IDLE   | line high; pops the FIFO head when one is waiting
//   START  | start bit (low) for one bit period
//   DATA   | eight data bits, LSB first
//   PARITY | parity bit (parity build only)
//   STOP   | stop bit (high) for one bit period

module uart_tx_port #(
  parameter int          DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd216
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  rw,
  input  logic [3:0]            address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  tx,
  output logic                  irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, state_nx;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic [7:0]    head;

  logic [15:0]   div;
  logic [15:0]   cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          irqen;
  logic          ovf;

  logic          wr_data, wr_div, wr_stat, wr_irqen;
  logic          push_ok, pop, bit_done;
  logic [7:0]    status;
  logic          tx_c;
  logic          unused_bits;

`ifdef UART_TX_PARITY_EN
  logic          odd;
  logic          par_bit;
`endif

  assign wr_data  = ce & rw & (address == 4'h0);
  assign wr_div   = ce & rw & (address == 4'h1);
  assign wr_stat  = ce & rw & (address == 4'h2);
  assign wr_irqen = ce & rw & (address == 4'h3);

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a store into a full FIFO is
  // still accepted then.
  assign push_ok  = wr_data & (~full | pop);
  assign bit_done = (cnt == 16'd0);

  // Upper store-data bits carry no register content.
  assign unused_bits = ^data_in[DATA_WIDTH-1:16];

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    tx_c     = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        tx_c = 1'b0;
        if (bit_done) state_nx = DATA;
      end
      DATA: begin
        tx_c = shift[0];
        if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_c = par_bit;
        if (bit_done) state_nx = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // tx decodes the state register so reset forces the line high at once.
  assign tx  = tx_c;
  assign irq = irqen & empty & (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Baud counter reloads on every bit boundary, so a DIV write lands on the
  // next bit rather than stretching the current one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      if (pop || (state != IDLE && bit_done)) cnt <= div;
      else if (cnt != 16'd0)                  cnt <= cnt - 16'd1;

      if (pop) begin
        shift   <= head;
        bit_idx <= 3'd0;
      end else if (state == DATA && bit_done) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     par_bit <= 1'b0;
    else if (pop) par_bit <= (^head) ^ odd;
  end
`endif

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div   <= DIV_RESET;
      irqen <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (wr_div)   div   <= data_in[15:0];
      if (wr_irqen) irqen <= data_in[0];
      if (wr_data && full && !pop) ovf <= 1'b1;
      else if (wr_stat && data_in[3]) ovf <= 1'b0;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        odd <= 1'b0;
    else if (wr_div) odd <= data_in[16];
  end
`endif

  assign status = {4'b0000, ovf, empty, full, (state != IDLE) | ~empty}
                | (8'(count) << 4);

  always_comb begin
    data_out = '0;
    if (ce && !rw) begin
      case (address)
        4'h1: begin
          data_out[15:0] = div;
`ifdef UART_TX_PARITY_EN
          data_out[16] = odd;
`endif
        end
        4'h2:    data_out[7:0] = status;
        4'h3:    data_out[0]   = irqen;
        default: data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
module tb_uart_tx_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        rw = 1'b0;
  logic [3:0]  address = 4'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        tx;
  logic        irq;

  int errors = 0;
  int checks = 0;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  uart_tx_port #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .DIV_RESET(16'd216)) dut (
    .clk(clk), .rst(rst), .ce(ce), .rw(rw), .address(address),
    .data_in(data_in), .data_out(data_out), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; rw = 1'b1; address = a; data_in = d;
    @(posedge clk);
    #1;
    ce = 1'b0; rw = 1'b0; data_in = 32'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    ce = 1'b1; rw = 1'b0; address = a;
    #1;
    d = data_out;
    ce = 1'b0;
  endtask

  // Called 1ns after the edge that entered START. Samples every bit mid-period,
  // checks busy on the last stop cycle, and returns 1ns after the IDLE entry edge.
  task automatic check_frame(input string tag, input logic [10:0] bits, input int len);
    logic [31:0] st;
    int h;
    h = len / 2;
    for (int k = 0; k < NB; k++) begin
      repeat (h) @(posedge clk);
      #1;
      chk($sformatf("%s bit%0d", tag, k), 32'(tx), 32'(bits[k]));
      if (k == NB - 1) begin
        repeat (len - h - 1) @(posedge clk);
        #1;
        bus_read(4'h2, st);
        chk($sformatf("%s busy last cycle", tag), 32'(st[0]), 32'd1);
        @(posedge clk);
        #1;
      end else begin
        repeat (len - h) @(posedge clk);
        #1;
      end
    end
  endtask

  logic [31:0] rd;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset irq", 32'(irq), 32'd0);
    chk("reset data_out", data_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus_read(4'h2, rd); chk("reset status", rd, 32'h04);
    bus_read(4'h1, rd); chk("reset div", rd, 32'd216);
    bus_read(4'h3, rd); chk("reset irqen", rd, 32'h0);
    bus_read(4'h0, rd); chk("data reads 0", rd, 32'h0);
    bus_read(4'h7, rd); chk("unmapped reads 0", rd, 32'h0);

    // 0x55 at the default divisor: 217 clocks per bit
    bus_write(4'h0, 32'h55);
    chk("t1 tx idle after push", 32'(tx), 32'd1);
    bus_read(4'h2, rd); chk("t1 status queued", rd, 32'h11);
    @(posedge clk);
    #1;
`ifdef UART_TX_PARITY_EN
    check_frame("t1", 11'b10010101010, 217);
`else
    check_frame("t1", 11'b01010101010, 217);
`endif
    bus_read(4'h2, rd); chk("t1 status done", rd, 32'h04);

    // DIV=3, back-to-back 0xA5, 0x3C
    bus_write(4'h1, 32'd3);
    bus_read(4'h1, rd); chk("t2 div readback", rd, 32'd3);
    bus_write(4'h0, 32'hA5);
    bus_write(4'h0, 32'h3C);
`ifdef UART_TX_PARITY_EN
    check_frame("t2a", 11'b10101001010, 4);
`else
    check_frame("t2a", 11'b01101001010, 4);
`endif
    chk("t2 idle gap tx", 32'(tx), 32'd1);
    bus_read(4'h2, rd); chk("t2 idle gap status", rd, 32'h11);
    @(posedge clk);
    #1;
`ifdef UART_TX_PARITY_EN
    check_frame("t2b", 11'b10001111000, 4);
`else
    check_frame("t2b", 11'b01001111000, 4);
`endif
    bus_read(4'h2, rd); chk("t2 status done", rd, 32'h04);

    // DIV=0: one byte in flight, then nine more; the ninth overflows
    bus_write(4'h1, 32'd0);
    bus_write(4'h0, 32'h01);
    for (int i = 0; i < 9; i++) bus_write(4'h0, 32'(8'h10 + i));
    bus_read(4'h2, rd); chk("t3 full+overflow", rd, 32'h8B);
    bus_write(4'h2, 32'h08);
    bus_read(4'h2, rd); chk("t3 overflow cleared", rd, 32'h83);
    begin
      int n;
      n = 0;
      bus_read(4'h2, rd);
      while (rd != 32'h04 && n < 400) begin
        @(posedge clk);
        #1;
        bus_read(4'h2, rd);
        n++;
      end
      chk("t3 drain", rd, 32'h04);
    end

    // DIV bit 16: odd-parity select in the parity build, ignored otherwise
    bus_write(4'h1, 32'h0001_0001);
    bus_read(4'h1, rd);
`ifdef UART_TX_PARITY_EN
    chk("div bit16", rd, 32'h0001_0001);
`else
    chk("div bit16", rd, 32'h0000_0001);
`endif

    // Interrupt behaviour with DIV=1
    bus_write(4'h1, 32'd1);
    bus_write(4'h3, 32'd1);
    chk("t4 irq idle enabled", 32'(irq), 32'd1);
    bus_write(4'h0, 32'h81);
    chk("t4 irq after push", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    chk("t4 irq start", 32'(irq), 32'd0);
    repeat (NB * 2 - 1) @(posedge clk);
    #1;
    chk("t4 irq last stop cycle", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    chk("t4 irq back in idle", 32'(irq), 32'd1);
    bus_read(4'h3, rd); chk("t4 irqen readback", rd, 32'd1);
    bus_write(4'h3, 32'd0);
    chk("t4 irq disabled", 32'(irq), 32'd0);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    bus_write(4'h0, 32'h07);
    @(posedge clk);
    #1;
    check_frame("t6 even", 11'b11000001110, 2);
    bus_write(4'h1, 32'h0001_0001);
    bus_write(4'h0, 32'h07);
    @(posedge clk);
    #1;
    check_frame("t6 odd", 11'b10000001110, 2);
`endif

    // Reset asserted during bit 4 of a frame, with a byte still queued
    bus_write(4'h1, 32'd3);
    bus_write(4'h0, 32'h00);
    bus_write(4'h0, 32'h00);
    repeat (17) @(posedge clk);
    #1;
    chk("t5 tx low in bit4", 32'(tx), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("t5 tx high on reset", 32'(tx), 32'd1);
    bus_read(4'h2, rd); chk("t5 status flushed", rd, 32'h04);
    bus_read(4'h1, rd); chk("t5 div restored", rd, 32'd216);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5 tx stays idle", 32'(tx), 32'd1);
    bus_read(4'h2, rd); chk("t5 status after release", rd, 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Memory-mapped UART transmitter peripheral on the microcontroller peripheral bus, responding to CPU stores and loads routed through the address decoder (`ce`/`rw` from the decoder, sub-address from `data_address[7:4]`). Bytes written by the CPU are buffered in a small FIFO and serialized 8N1 on `tx` at a programmable baud rate. A level interrupt is raised toward the interrupt controller when transmission completes and the FIFO drains.

## Interface
- `DATA_WIDTH`, 32: CPU data bus width.
- `FIFO_DEPTH`, 8: transmit FIFO entries; power of two, 2 to 16.
- `DIV_RESET`, 16'd216: baud divisor reset value (115200 baud at 25 MHz).
- `clk`  in  1: system clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `ce`  in  1: chip enable from the decoder.
- `rw`  in  1: 1 = write (store), 0 = read (load).
- `address`  in  4: register select.
- `data_in`  in  DATA_WIDTH: CPU store data.
- `data_out`  out  DATA_WIDTH: register read data; combinational; 0 when not selected.
- `tx`  out  1: serial output; idle high.
- `irq`  out  1: interrupt request to the controller's `irq_source` input.

## Operation
- Register map:
  - 0x0 DATA: write pushes `data_in[7:0]`; reads 0.
  - 0x1 DIV: 16-bit divisor, R/W; bit period = DIV+1 clocks.
  - 0x2 STATUS: read-only except bit 3. Bit 0 = busy (FSM not IDLE or FIFO non-empty); bit 1 = FIFO full; bit 2 = FIFO empty; bit 3 = overflow (sticky; writing 1 clears it); bits [7:4] = FIFO count.
  - 0x3 IRQEN: bit 0 enables `irq`, R/W.
  - Other addresses: writes ignored, reads 0.
- Write when FIFO full: byte dropped, overflow set, FIFO unchanged.
- FSM states:
  - IDLE (`tx`=1): with FIFO non-empty, pop the head into the shift register and go to START.
  - START (`tx`=0): one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each.
  - STOP (`tx`=1): one bit period, then IDLE.
- Baud counter:
  - Loads DIV on each state entry and counts down to 0.
  - Bit period ends on the cycle the count reaches 0.
  - DIV written mid-frame takes effect at the next bit boundary.
  - DIV=0 gives one clock per bit.
- `irq` = IRQEN[0] & FIFO empty & FSM in IDLE. Level-sensitive; cleared by pushing data or disabling IRQEN.
- Simultaneous push and pop in one cycle: count unchanged; a push into a full FIFO during a pop is accepted.

## Timing
- Reset values: `tx`=1, `irq`=0, `data_out`=0, FIFO empty, DIV=DIV_RESET, IRQEN=0, overflow=0, FSM in IDLE.
- Write to DATA at edge N with FSM idle:
  - FIFO non-empty after edge N.
  - Pop and START entry at edge N+1; `tx` falls after edge N+1.
- Frame length: exactly 10×(DIV+1) clocks from `tx` falling to FSM re-entering IDLE.
- Back-to-back frames: the next start bit follows the stop bit after one IDLE cycle.
- Reset asserted mid-frame: `tx` goes high immediately (asynchronously) and the FIFO is flushed.
- Reads have no side effects.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: PARITY state inserted between DATA and STOP; transmits the even parity of the 8 data bits; frame = 11×(DIV+1) clocks. DIV register bit 16 selects odd parity when 1 (reset 0).
  - Undefined: 8N1 only; DIV bit 16 reads 0 and ignores writes.

## Test plan
- Reset with DIV default; write 0x55 to DATA -> `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit held 217 clocks; frame is 2170 clocks.
- DIV=3; write 0xA5, 0x3C back-to-back -> two frames of 40 clocks each, with one IDLE cycle between them; STATUS busy=1 until the final stop bit completes.
- DIV=0; write 9 bytes while the FIFO is stalled by the first frame -> the 9th write is accepted or dropped according to FIFO count; with FIFO_DEPTH=8, the 9th write reports STATUS full=1 and overflow=1; write STATUS bit 3 -> overflow=0.
- IRQEN=1; write one byte -> `irq`=0 during the frame, rises the cycle after returning to IDLE with the FIFO empty; write IRQEN=0 -> `irq`=0.
- Assert `rst` low during bit 4 of a frame -> `tx`=1 immediately, STATUS=0x04, DIV=216.
- With `UART_TX_PARITY_EN` and DIV=1, write 0x07 -> parity bit 1 (even), frame is 22 clocks.
